// File: rtl/restoring_div_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t     : FSM encoding (IDLE, RUN, FIN)
//   cnt_width() : width of the iteration counter for a W-bit divider
package restoring_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // The counter must hold the value W itself, so it needs clog2(W+1) bits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/restoring_div_seq_if.sv
// Handshake and operand/result bundle for restoring_div_seq.
//   start, dividend, divisor : request side (driven by master)
//   busy, done               : progress flags (driven by slave)
//   quotient, remainder      : registered results (driven by slave)
//   div_by_zero              : set with the results when divisor was 0
interface restoring_div_seq_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div_seq_step.sv
// One iteration of the restoring division datapath (combinational).
//   a, qr, d       : partial remainder, dividend/quotient shifter, divisor
//   a_next, qr_next: state after shift, trial subtract and restore
module restoring_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] qr,
  input  logic [W-1:0] d,
  output logic [W:0]   a_next,
  output logic [W-1:0] qr_next
);

  logic [W:0] a_sh;
  logic [W:0] t;
  logic       unused_msb;

  // The partial remainder stays below D, so its MSB is always zero and
  // is shifted out without loss.
  assign unused_msb = a[W];

  always_comb begin
    a_sh    = {a[W-1:0], qr[W-1]};
    t       = a_sh - {1'b0, d};
    a_next  = a_sh;
    qr_next = {qr[W-2:0], 1'b0};
    if (!t[W]) begin
      a_next  = t;
      qr_next = {qr[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_div_seq.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : start/dividend/divisor in; busy/done/quotient/remainder/
//         div_by_zero out (slave side of restoring_div_seq_if)
// Accept in IDLE or FIN; W iterations in RUN; results latched on entry
// to FIN, which lasts one cycle. Divide by zero goes straight to FIN.
module restoring_div_seq
  import restoring_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  restoring_div_seq_if.slave  bus
);

  localparam int CW = cnt_width(W);

  state_t        state;
  logic [W:0]    a;
  logic [W-1:0]  qr;
  logic [W-1:0]  d;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quotient_r;
  logic [W-1:0]  remainder_r;
  logic          dbz_r;

  logic [W:0]    a_next;
  logic [W-1:0]  qr_next;

  restoring_div_step #(.W(W)) u_step (
    .a       (a),
    .qr      (qr),
    .d       (d),
    .a_next  (a_next),
    .qr_next (qr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      qr          <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        // FIN accepts a new request exactly like IDLE so divisions can
        // run back to back.
        IDLE, FIN: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state       <= FIN;
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end else begin
              state <= RUN;
              a     <= '0;
              qr    <= bus.dividend;
              d     <= bus.divisor;
              cnt   <= CW'(W);
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a   <= a_next;
          qr  <= qr_next;
          cnt <= cnt - 1'b1;
          // The last iteration's result goes straight to the outputs.
          if (cnt == CW'(1)) begin
            state       <= FIN;
            quotient_r  <= qr_next;
            remainder_r <= a_next[W-1:0];
            dbz_r       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == FIN);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_div_seq.sv
// Directed self-checking bench for restoring_div_seq at W = 8.
module tb_restoring_div_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  restoring_div_seq_if #(.W(8)) bus ();

  restoring_div_seq #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request, then wait (bounded) for done. lat counts edges after
  // the accepting edge until done is seen; bcnt counts busy samples.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bcnt);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.done); end
    total++; if (bus.quotient !== 8'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", bus.quotient); end
    total++; if (bus.remainder !== 8'd0) begin bad++; $display("FAIL reset_r got=%0d want=0", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%0b want=0", bus.div_by_zero); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc;
    run_div(8'd100, 8'd7, lat, bc);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b want=1", bus.done); end
    total++; if (lat + 1 != 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat + 1); end
    total++; if (bc != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_fin got=%0b want=0", bus.busy); end
    total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL basic_q got=%0d want=14", bus.quotient); end
    total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL basic_r got=%0d want=2", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%0b want=0", bus.div_by_zero); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b want=0", bus.done); end
    total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL basic_q_hold got=%0d want=14", bus.quotient); end
  endtask

  task automatic test_boundary();
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd3, 8'd255};
    logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [7:0] vr [4] = '{8'd0,   8'd5, 8'd0, 8'd0};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], lat, bc);
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL bound_done[%0d] got=%0b want=1", i, bus.done); end
      total++; if (bus.quotient !== vq[i]) begin bad++; $display("FAIL bound_q[%0d] %0d/%0d got=%0d want=%0d", i, va[i], vb[i], bus.quotient, vq[i]); end
      total++; if (bus.remainder !== vr[i]) begin bad++; $display("FAIL bound_r[%0d] %0d/%0d got=%0d want=%0d", i, va[i], vb[i], bus.remainder, vr[i]); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_div(8'd200, 8'd0, lat, bc);
    total++; if (lat + 1 != 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat + 1); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL dbz_done got=%0b want=1", bus.done); end
    total++; if (bus.quotient !== 8'd255) begin bad++; $display("FAIL dbz_q got=%0d want=255", bus.quotient); end
    total++; if (bus.remainder !== 8'd200) begin bad++; $display("FAIL dbz_r got=%0d want=200", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%0b want=1", bus.div_by_zero); end
    tick();
    total++; if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_hold got=%0b want=1", bus.div_by_zero); end
    run_div(8'd17, 8'd5, lat, bc);
    total++; if (bus.quotient !== 8'd3) begin bad++; $display("FAIL dbz_next_q got=%0d want=3", bus.quotient); end
    total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL dbz_next_r got=%0d want=2", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%0b want=0", bus.div_by_zero); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    // Request while busy must be ignored; then scramble the inputs.
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'hAA;
    bus.divisor  = 8'd0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%0b want=1", bus.done); end
    total++; if (bus.quotient !== 8'd14) begin bad++; $display("FAIL b2b_first_q got=%0d want=14", bus.quotient); end
    total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL b2b_first_r got=%0d want=2", bus.remainder); end
    // Now in FIN: start the next division without a gap.
    run_div(8'd9, 8'd3, lat, bc);
    total++; if (lat + 1 != 9) begin bad++; $display("FAIL b2b_second_latency got=%0d want=9", lat + 1); end
    total++; if (bc != 8) begin bad++; $display("FAIL b2b_second_busy got=%0d want=8", bc); end
    total++; if (bus.quotient !== 8'd3) begin bad++; $display("FAIL b2b_second_q got=%0d want=3", bus.quotient); end
    total++; if (bus.remainder !== 8'd0) begin bad++; $display("FAIL b2b_second_r got=%0d want=0", bus.remainder); end
    tick();
  endtask

  task automatic test_rst_abort();
    int lat, bc, seen;
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd3;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b want=0", bus.done); end
    total++; if (bus.quotient !== 8'd0) begin bad++; $display("FAIL abort_q got=%0d want=0", bus.quotient); end
    total++; if (bus.remainder !== 8'd0) begin bad++; $display("FAIL abort_r got=%0d want=0", bus.remainder); end
    total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL abort_dbz got=%0b want=0", bus.div_by_zero); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    // Reset wins over a simultaneous start.
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd6;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_priority got=%0b want=0", bus.busy); end
    tick();
    run_div(8'd50, 8'd6, lat, bc);
    total++; if (bus.quotient !== 8'd8) begin bad++; $display("FAIL fresh_q got=%0d want=8", bus.quotient); end
    total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL fresh_r got=%0d want=2", bus.remainder); end
    tick();
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [7:0] a, b, eq, er;
    logic edz;
    for (int i = 0; i < 3000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'd255; er = a; edz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0;
      end
      run_div(a, b, lat, bc);
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL sweep_timeout %0d/%0d", a, b); end
      total++; if (bus.quotient !== eq) begin bad++; $display("FAIL sweep_q %0d/%0d got=%0d want=%0d", a, b, bus.quotient, eq); end
      total++; if (bus.remainder !== er) begin bad++; $display("FAIL sweep_r %0d/%0d got=%0d want=%0d", a, b, bus.remainder, er); end
      total++; if (bus.div_by_zero !== edz) begin bad++; $display("FAIL sweep_dbz %0d/%0d got=%0b want=%0b", a, b, bus.div_by_zero, edz); end
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_rst_abort();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
